// File: rtl/truth_table_scanner.sv
// Scans every input vector of a 4-input SOP/POS gate pair and builds minterm masks.
// TT_GOLDEN_EN adds a comparison of the final SOP mask against the GOLDEN mask.
module truth_table_scanner #(
   parameter int N_IN = 4,
   parameter int SETTLE = 1,
   parameter logic [2**N_IN-1:0] GOLDEN = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic [N_IN-1:0]      abcd,
   input  logic                 f_sop,
   input  logic                 f_pos,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   mask_sop,
   output logic [2**N_IN-1:0]   mask_pos,
   output logic                 mismatch,
   output logic [N_IN-1:0]      mismatch_idx,
   output logic                 golden_fail
);

   localparam int W = 2**N_IN;
   localparam logic [N_IN-1:0] LAST = N_IN'(W - 1);
   localparam logic [3:0] CNT_END = 4'(SETTLE - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t state, state_nxt;
   logic [3:0] cnt;
   logic [N_IN-1:0] idx;
   logic [W-1:0] sop_nxt, pos_nxt;
   logic accept, sample, last;

   assign accept = (state == S_IDLE) && start;
   assign sample = (state == S_SAMPLE);
   assign last = (idx == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (start) state_nxt = S_SETTLE;
         S_SETTLE: if (cnt == CNT_END) state_nxt = S_SAMPLE;
         S_SAMPLE: state_nxt = last ? S_DONE : S_SETTLE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      sop_nxt = mask_sop;
      pos_nxt = mask_pos;
      sop_nxt[idx] = f_sop;
      pos_nxt[idx] = f_pos;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         idx          <= '0;
         mask_sop     <= '0;
         mask_pos     <= '0;
         mismatch     <= 1'b0;
         mismatch_idx <= '0;
      end else if (accept) begin
         cnt          <= '0;
         idx          <= '0;
         mask_sop     <= '0;
         mask_pos     <= '0;
         mismatch     <= 1'b0;
         mismatch_idx <= '0;
      end else if (state == S_SETTLE) begin
         cnt <= (cnt == CNT_END) ? 4'd0 : cnt + 4'd1;
      end else if (sample) begin
         mask_sop <= sop_nxt;
         mask_pos <= pos_nxt;
         if ((f_sop != f_pos) && !mismatch) begin
            mismatch     <= 1'b1;
            mismatch_idx <= idx;
         end
         if (!last) idx <= idx + N_IN'(1);
      end
   end

`ifdef TT_GOLDEN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               golden_fail <= 1'b0;
      else if (accept)          golden_fail <= 1'b0;
      else if (sample && last)  golden_fail <= (sop_nxt != GOLDEN);
   end
`else
   logic unused_golden;
   assign unused_golden = ^GOLDEN;
   assign golden_fail = 1'b0;
`endif

   assign abcd = idx;
   assign busy = (state == S_SETTLE) || (state == S_SAMPLE);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: table vectors, random truth tables, corner sequences.
// Networks are modelled as 16-entry truth tables looked up by abcd.
module tb_truth_table_scanner;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start1 = 1'b0, start2 = 1'b0;
   logic [15:0] tt_sop = '0, tt_pos = '0;

   logic [3:0] abcd1, abcd2, midx1, midx2;
   logic busy1, done1, mm1, gf1, busy2, done2, mm2, gf2;
   logic [15:0] ms1, mp1, ms2, mp2;
   logic fs1, fp1, fs2, fp2;

   assign fs1 = tt_sop[abcd1];
   assign fp1 = tt_pos[abcd1];
   assign fs2 = tt_sop[abcd2];
   assign fp2 = tt_pos[abcd2];

   always #5 clk = ~clk;

   truth_table_scanner #(.N_IN(4), .SETTLE(1), .GOLDEN(16'hAAAA)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abcd(abcd1),
      .f_sop(fs1), .f_pos(fp1), .busy(busy1), .done(done1),
      .mask_sop(ms1), .mask_pos(mp1), .mismatch(mm1),
      .mismatch_idx(midx1), .golden_fail(gf1));

   truth_table_scanner #(.N_IN(4), .SETTLE(3), .GOLDEN(16'hAAAA)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abcd(abcd2),
      .f_sop(fs2), .f_pos(fp2), .busy(busy2), .done(done2),
      .mask_sop(ms2), .mask_pos(mp2), .mismatch(mm2),
      .mismatch_idx(midx2), .golden_fail(gf2));

   int n_cmp = 0, n_bad = 0;
   bit sel = 0;

   typedef struct {
      bit          dut;
      logic [15:0] sop;
      logic [15:0] pos;
      bit          exp_mm;
      int          exp_idx;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic int first_diff(input logic [15:0] a, input logic [15:0] b);
      int r = 0;
      for (int i = 15; i >= 0; i--) if (a[i] != b[i]) r = i;
      return r;
   endfunction

   function automatic bit exp_golden(input logic [15:0] sop);
`ifdef TT_GOLDEN_EN
      return sop != 16'hAAAA;
`else
      return 1'b0 & sop[0];
`endif
   endfunction

   task automatic drive_start(input bit v);
      if (sel) start2 = v;
      else     start1 = v;
   endtask

   function automatic logic [3:0] c_abcd();
      return sel ? abcd2 : abcd1;
   endfunction

   function automatic logic c_done();
      return sel ? done2 : done1;
   endfunction

   function automatic logic c_busy();
      return sel ? busy2 : busy1;
   endfunction

   task automatic scan(input bit s, input logic [15:0] sop, input logic [15:0] pos,
                       input bit repulse, input bit exp_mm, input int exp_idx);
      int cnt, errs, per, ndone;
      sel = s;
      per = s ? 4 : 2;
      tt_sop = sop;
      tt_pos = pos;
      @(negedge clk);
      drive_start(1'b1);
      @(posedge clk);
      #1;
      drive_start(1'b0);
      chk("busy_after_accept", 32'(c_busy()), 32'd1);
      cnt = 0;
      errs = 0;
      while (!c_done() && cnt < 300) begin
         if (32'(c_abcd()) != 32'(cnt / per)) errs++;
         drive_start(repulse && (cnt == 3 || cnt == 20));
         @(posedge clk);
         #1;
         cnt++;
      end
      drive_start(1'b0);
      chk("latency", 32'(cnt), 32'(16 * per));
      chk("abcd_hold_sequence", 32'(errs), 32'd0);
      chk("busy_in_done", 32'(c_busy()), 32'd0);
      chk("mask_sop", 32'(s ? ms2 : ms1), 32'(sop));
      chk("mask_pos", 32'(s ? mp2 : mp1), 32'(pos));
      chk("mismatch", 32'(s ? mm2 : mm1), 32'(exp_mm));
      if (exp_mm) chk("mismatch_idx", 32'(s ? midx2 : midx1), 32'(exp_idx));
      chk("golden_fail", 32'(s ? gf2 : gf1), 32'(exp_golden(sop)));
      ndone = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (c_done()) ndone++;
      end
      chk("single_done", 32'(ndone), 32'd0);
      chk("idle_after_done", {30'd0, c_busy(), c_done()}, 32'd0);
      chk("abcd_holds_last", 32'(c_abcd()), 32'd15);
      chk("mask_sop_holds", 32'(s ? ms2 : ms1), 32'(sop));
   endtask

   vec_t vt[$];
   logic [15:0] rs, rp;

   initial begin
      vt.push_back('{0, 16'hAAAA, 16'hAAAA, 0, 0});
      vt.push_back('{0, 16'hAAAA, 16'hA88A, 1, 5});
      vt.push_back('{1, 16'h8000, 16'h8000, 0, 0});
      vt.push_back('{0, 16'h5555, 16'hAAAA, 1, 0});
      vt.push_back('{0, 16'h0000, 16'h8000, 1, 15});
      vt.push_back('{1, 16'hFFFF, 16'hFFFF, 0, 0});
      vt.push_back('{1, 16'h0100, 16'h0300, 1, 9});

      #12;
      chk("reset_outputs1", {busy1, done1, mm1, gf1, ms1, mp1, midx1, abcd1}, 32'd0);
      chk("reset_outputs2", {busy2, done2, mm2, gf2, ms2, mp2, midx2, abcd2}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vt[i]) scan(vt[i].dut, vt[i].sop, vt[i].pos, 0, vt[i].exp_mm, vt[i].exp_idx);

      scan(0, 16'hAAAA, 16'hAAAA, 1, 0, 0);
      scan(0, 16'h5555, 16'h5555, 0, 0, 0);

      sel = 0;
      tt_sop = 16'hFFFF;
      tt_pos = 16'h0F0F;
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_reset_clear",
          {busy1, done1, mm1, gf1, ms1, mp1, midx1, abcd1}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      scan(0, 16'h0000, 16'h0000, 0, 0, 0);

      for (int k = 0; k < 10; k++) begin
         rs = 16'($urandom);
         rp = (k % 3 == 0) ? rs : 16'($urandom);
         scan(k >= 8, rs, rp, 0, rs != rp, first_diff(rs, rp));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
